led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen_if.sv | 13 +
 rtl/led_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Control and LED drive bundle for led_pattern_gen.
// The master drives run enable and pattern select; the slave returns LED drive and the step pulse.
interface led_pattern_gen_if #(
    parameter int unsigned NUM_LEDS = 4
);
    logic                en;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] led;
    logic                tick;

    modport master (output en, output mode, input led, input tick);
    modport slave  (input en, input mode, output led, output tick);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator with four patterns: binary count, bouncing dot, PWM breathe, and hold.
// A prescaler sets the pattern step rate, and tick pulses once for every step.
module led_pattern_gen #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned DIV      = 900000,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic               clki,
    input  logic               resetn,
    led_pattern_gen_if.slave   bus
);

    localparam int unsigned PRESC_W = $clog2(DIV);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_BOUNCE  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    mode_e               mode_q,   mode_d;
    logic [PRESC_W-1:0]  presc_q,  presc_d;
    logic [PWM_BITS-1:0] p_q,      p_d;
    logic [NUM_LEDS-1:0] cnt_q,    cnt_d;
    logic [NUM_LEDS-1:0] pos_q,    pos_d;
    logic                pos_up_q, pos_up_d;
    logic [PWM_BITS-1:0] lvl_q,    lvl_d;
    logic                lvl_up_q, lvl_up_d;
    logic [NUM_LEDS-1:0] led_q,    led_d;
    logic                tick_q,   tick_d;

    mode_e mode_in;
    mode_e eff_mode;
    logic  changed;
    logic  reinit;
    logic  step;

    // State register; reset discards every bit of progress immediately.
    always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
            mode_q   <= MODE_COUNT;
            presc_q  <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            pos_q    <= NUM_LEDS'(1);
            pos_up_q <= 1'b1;
            lvl_q    <= '0;
            lvl_up_q <= 1'b1;
            led_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            pos_up_q <= pos_up_d;
            lvl_q    <= lvl_d;
            lvl_up_q <= lvl_up_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
        end
    end

    // On a mode-change edge the incoming mode governs; entering HOLD freezes the pattern only.
    always_comb begin
        mode_in  = mode_e'(bus.mode);
        changed  = (mode_in != mode_q);
        eff_mode = changed ? mode_in : mode_q;
        reinit   = changed && (eff_mode != MODE_HOLD);
        step     = bus.en && !reinit && (presc_q == PRESC_MAX);

        mode_d   = mode_in;
        presc_d  = presc_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        pos_up_d = pos_up_q;
        lvl_d    = lvl_q;
        lvl_up_d = lvl_up_q;
        led_d    = led_q;
        tick_d   = step;

        if (reinit) begin
            presc_d = '0;
            p_d     = '0;
        end else if (bus.en) begin
            presc_d = step ? '0 : presc_q + PRESC_W'(1);
            if (eff_mode != MODE_HOLD) begin
                p_d = p_q + PWM_BITS'(1);
            end
        end

        case (eff_mode)
            MODE_COUNT: begin
                if (reinit) begin
                    cnt_d = '0;
                end else if (step) begin
                    cnt_d = cnt_q + NUM_LEDS'(1);
                end
                led_d = cnt_d;
            end
            MODE_BOUNCE: begin
                if (reinit) begin
                    pos_d    = NUM_LEDS'(1);
                    pos_up_d = 1'b1;
                end else if (step) begin
                    if (pos_up_q) begin
                        if (pos_q[NUM_LEDS-1]) begin
                            pos_d    = pos_q >> 1;
                            pos_up_d = 1'b0;
                        end else begin
                            pos_d = pos_q << 1;
                        end
                    end else begin
                        if (pos_q[0]) begin
                            pos_d    = pos_q << 1;
                            pos_up_d = 1'b1;
                        end else begin
                            pos_d = pos_q >> 1;
                        end
                    end
                end
                led_d = pos_d;
            end
            MODE_BREATHE: begin
                if (reinit) begin
                    lvl_d    = '0;
                    lvl_up_d = 1'b1;
                end else if (step) begin
                    if (lvl_up_q) begin
                        if (lvl_q == LEVEL_MAX) begin
                            lvl_d    = lvl_q - PWM_BITS'(1);
                            lvl_up_d = 1'b0;
                        end else begin
                            lvl_d = lvl_q + PWM_BITS'(1);
                        end
                    end else begin
                        if (lvl_q == '0) begin
                            lvl_d    = PWM_BITS'(1);
                            lvl_up_d = 1'b1;
                        end else begin
                            lvl_d = lvl_q - PWM_BITS'(1);
                        end
                    end
                end
                led_d = {NUM_LEDS{p_d < lvl_d}};
            end
            default: begin
                led_d = led_q;
            end
        endcase
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: a step-index reference model checked every cycle,
// plus directed scenarios that have hand-computed LED values.
module tb_led_pattern_gen;

    localparam int N      = 4;
    localparam int DIV    = 4;
    localparam int PWMB   = 2;
    localparam int LEVELS = 1 << PWMB;
    localparam int BMAX   = LEVELS - 1;

    logic clki   = 1'b0;
    logic resetn = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    led_pattern_gen_if #(.NUM_LEDS(N)) bus ();

    led_pattern_gen #(.NUM_LEDS(N), .DIV(DIV), .PWM_BITS(PWMB)) dut (
        .clki   (clki),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clki = ~clki;

    // Reference model: each pattern is derived from the number of steps taken since its re-init.
    int       m_mode_q = 0;
    int       m_presc  = 0;
    int       m_p      = 0;
    int       m_kc     = 0;
    int       m_kb     = 0;
    int       m_kr     = 0;
    logic [N-1:0] m_led  = '0;
    logic         m_tick = 1'b0;

    function automatic logic [N-1:0] pattern(input int md, input int k, input int p);
        int idx;
        int lvl;
        logic [N-1:0] one;
        one = N'(1);
        case (md)
            0: return N'(k % (1 << N));
            1: begin
                idx = k % (2 * (N - 1));
                if (idx > N - 1) idx = 2 * (N - 1) - idx;
                return one << idx;
            end
            default: begin
                idx = k % (2 * BMAX);
                lvl = (idx <= BMAX) ? idx : 2 * BMAX - idx;
                return (p < lvl) ? {N{1'b1}} : {N{1'b0}};
            end
        endcase
    endfunction

    initial forever begin : model
        int md;
        int eff;
        int k;
        @(posedge clki or negedge resetn);
        if (!resetn) begin
            m_mode_q = 0; m_presc = 0; m_p = 0;
            m_kc = 0; m_kb = 0; m_kr = 0;
            m_led = '0; m_tick = 1'b0;
        end else begin
            md = int'(bus.mode);
            if (md != m_mode_q && md != 3) begin
                m_presc = 0;
                m_p     = 0;
                m_tick  = 1'b0;
                case (md)
                    0: m_kc = 0;
                    1: m_kb = 0;
                    default: m_kr = 0;
                endcase
                m_led = pattern(md, 0, 0);
            end else begin
                eff    = (md != m_mode_q) ? md : m_mode_q;
                m_tick = bus.en && (m_presc == DIV - 1);
                if (bus.en) begin
                    m_presc = (m_presc + 1) % DIV;
                    if (eff != 3) m_p = (m_p + 1) % LEVELS;
                end
                if (eff != 3) begin
                    case (eff)
                        0: begin if (m_tick) m_kc++; k = m_kc; end
                        1: begin if (m_tick) m_kb++; k = m_kb; end
                        default: begin if (m_tick) m_kr++; k = m_kr; end
                    endcase
                    m_led = pattern(eff, k, m_p);
                end
            end
            m_mode_q = md;
        end
    end

    // Compare every cycle, away from the active edge.
    initial forever begin
        @(negedge clki);
        compared++;
        if (bus.led !== m_led) begin
            mismatched++;
            $display("FAIL model_led t=%0t: dut=%b model=%b", $time, bus.led, m_led);
        end
        compared++;
        if (bus.tick !== m_tick) begin
            mismatched++;
            $display("FAIL model_tick t=%0t: dut=%b model=%b", $time, bus.tick, m_tick);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clki);
    endtask

    logic [N-1:0] bounce_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    int           duty_exp   [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    initial begin
        int ones;
        bus.en   = 1'b0;
        bus.mode = 2'd0;
        #1;
        check("reset_led", 32'(bus.led), 32'h0);
        check("reset_tick", 32'(bus.tick), 32'h0);
        edges(2);
        resetn = 1'b1;
        bus.en = 1'b1;

        // Binary count: first step on the DIV-th edge, then wraps after 16 steps.
        edges(3);
        check("count_pre_step_led", 32'(bus.led), 32'h0);
        check("count_pre_step_tick", 32'(bus.tick), 32'h0);
        edges(1);
        check("count_first_led", 32'(bus.led), 32'h1);
        check("count_first_tick", 32'(bus.tick), 32'h1);
        edges(1);
        check("count_tick_single", 32'(bus.tick), 32'h0);
        edges(55);
        check("count_all_ones", 32'(bus.led), 32'hF);
        edges(4);
        check("count_wrap", 32'(bus.led), 32'h0);

        // Pause at 0101 with the prescaler at 2.
        edges(22);
        check("pause_entry_led", 32'(bus.led), 32'h5);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            check("pause_led", 32'(bus.led), 32'h5);
            check("pause_tick", 32'(bus.tick), 32'h0);
        end
        bus.en = 1'b1;
        edges(1);
        check("resume_one_edge", 32'(bus.led), 32'h5);
        edges(1);
        check("resume_two_edges", 32'(bus.led), 32'h6);
        check("resume_tick", 32'(bus.tick), 32'h1);

        // Bouncing dot.
        bus.mode = 2'd1;
        edges(1);
        check("bounce_init", 32'(bus.led), 32'h1);
        for (int i = 0; i < 7; i++) begin
            edges(4);
            check("bounce_step", 32'(bus.led), 32'(bounce_exp[i]));
        end
        edges(4);
        check("bounce_at_0100", 32'(bus.led), 32'h4);

        // Reset pulse that lies entirely between two clock edges.
        #2 resetn = 1'b0;
        #1;
        check("midcycle_reset_led", 32'(bus.led), 32'h0);
        check("midcycle_reset_tick", 32'(bus.tick), 32'h0);
        #1 resetn = 1'b1;
        edges(1);
        check("mode_q_after_reset", 32'(bus.led), 32'h1);

        // Breathe: measure the duty over each 4-cycle PWM window.
        bus.mode = 2'd2;
        edges(1);
        for (int s = 0; s < 8; s++) begin
            ones = 0;
            for (int c = 0; c < 4; c++) begin
                if (bus.led != '0 && bus.led != '1) check("breathe_uniform", 32'(bus.led), 32'h0);
                if (bus.led[0]) ones++;
                edges(1);
            end
            check("breathe_duty", 32'(ones), 32'(duty_exp[s]));
        end

        // Hold at 0011, then return to count.
        bus.mode = 2'd0;
        edges(1);
        check("count_reinit", 32'(bus.led), 32'h0);
        edges(12);
        check("count_at_3", 32'(bus.led), 32'h3);
        bus.mode = 2'd3;
        for (int i = 0; i < 20; i++) begin
            edges(1);
            check("hold_led", 32'(bus.led), 32'h3);
        end
        bus.mode = 2'd0;
        edges(1);
        check("unhold_reinit", 32'(bus.led), 32'h0);
        edges(3);
        check("unhold_pre_step", 32'(bus.led), 32'h0);
        check("unhold_pre_tick", 32'(bus.tick), 32'h0);
        edges(1);
        check("unhold_step", 32'(bus.led), 32'h1);
        check("unhold_tick", 32'(bus.tick), 32'h1);

        // Mode change still re-initialises while disabled.
        edges(4);
        check("count_at_2", 32'(bus.led), 32'h2);
        bus.en   = 1'b0;
        bus.mode = 2'd1;
        edges(1);
        check("change_while_disabled", 32'(bus.led), 32'h1);
        edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
